// File: rtl/lpddr2_pkg.sv
// Shared types and default widths for the CPU-to-LPDDR2 Avalon bridge.
package lpddr2_pkg;
  localparam int LPDDR2_ADDR_W = 27;
  localparam int LPDDR2_DATA_W = 32;

  localparam logic CMD_RD = 1'b0;
  localparam logic CMD_WR = 1'b1;

  typedef enum logic [2:0] {INIT, IDLE, WR, RD_CMD, RD_WAIT} bridge_state_t;

  typedef struct packed {
    logic                     kind;
    logic [LPDDR2_ADDR_W-1:0] addr;
    logic [LPDDR2_DATA_W-1:0] data;
  } mem_cmd_t;
endpackage

// File: rtl/lpddr2_avalon_bridge_req_edge_slot.sv
// Request edge detect with a one-deep pending slot; hands the FSM the next
// command (slot first, then a fresh rise) whenever take is high.
module req_edge_slot
  import lpddr2_pkg::*;
#(
  parameter int ADDR_W = LPDDR2_ADDR_W,
  parameter int DATA_W = LPDDR2_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rreq,
  input  logic              wreq,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              take,
  output logic              cmd_valid,
  output logic              cmd_kind,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [DATA_W-1:0] cmd_data,
  output logic              pend_valid,
  output logic              err_overflow
);
  typedef struct packed {
    logic              kind;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cmd_t;

  logic rreq_q, wreq_q, w_rise, r_rise;
  logic slot_v_q, slot_v_d, ovf_set;
  cmd_t slot_q, slot_d, new_w, new_r, first, cmd;

  assign w_rise = wreq & ~wreq_q;
  assign r_rise = rreq & ~rreq_q;
  assign new_w  = {CMD_WR, addr, wdata};
  assign new_r  = {CMD_RD, addr, {DATA_W{1'b0}}};
  // store-then-load when both rise together
  assign first  = w_rise ? new_w : new_r;

  always_comb begin
    cmd_valid = 1'b0;
    cmd       = slot_q;
    slot_v_d  = slot_v_q;
    slot_d    = slot_q;
    ovf_set   = 1'b0;
    if (take && !slot_v_q) begin
      cmd_valid = w_rise | r_rise;
      cmd       = first;
      if (w_rise && r_rise) begin
        slot_v_d = 1'b1;
        slot_d   = new_r;
      end
    end else begin
      if (take) begin
        cmd_valid = 1'b1;
        slot_v_d  = 1'b0;
      end
      // slot may have just been freed by take; only one new entry fits
      if (w_rise | r_rise) begin
        if (slot_v_d) begin
          ovf_set = 1'b1;
        end else begin
          slot_v_d = 1'b1;
          slot_d   = first;
          ovf_set  = w_rise & r_rise;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rreq_q       <= 1'b0;
      wreq_q       <= 1'b0;
      slot_v_q     <= 1'b0;
      slot_q       <= '0;
      err_overflow <= 1'b0;
    end else begin
      rreq_q   <= rreq;
      wreq_q   <= wreq;
      slot_v_q <= slot_v_d;
      slot_q   <= slot_d;
      if (ovf_set) err_overflow <= 1'b1;
    end
  end

  assign cmd_kind   = cmd.kind;
  assign cmd_addr   = cmd.addr;
  assign cmd_data   = cmd.data;
  assign pend_valid = slot_v_q;
endmodule

// File: rtl/lpddr2_avalon_bridge.sv
// Converts level-style CPU read/write requests into single-beat Avalon-MM
// transactions on the LPDDR2 controller local port.
module lpddr2_avalon_bridge
  import lpddr2_pkg::*;
#(
  parameter int ADDR_W  = LPDDR2_ADDR_W,
  parameter int DATA_W  = LPDDR2_DATA_W,
  parameter int TIMEOUT = 1023
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   cpu_address,
  input  logic [DATA_W-1:0]   cpu_write_data,
  input  logic                cpu_rreq,
  input  logic                cpu_wreq,
  output logic [DATA_W-1:0]   cpu_read_data,
  output logic                cpu_busy,
  output logic                cpu_rdata_valid,
  input  logic                init_done,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_read,
  output logic                avm_write,
  output logic [DATA_W-1:0]   avm_writedata,
  output logic [DATA_W/8-1:0] avm_byteenable,
  input  logic                avm_waitrequest,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_readdatavalid,
  output logic                err_timeout,
  output logic                err_overflow
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  bridge_state_t     state, done_state;
  logic [ADDR_W-1:0] cmd_addr, sl_addr;
  logic [DATA_W-1:0] cmd_data, sl_data;
  logic [CNT_W-1:0]  cnt;
  logic              take, sl_valid, sl_kind, pend_valid;

  assign take = (state == IDLE) && init_done;
  // a lost init_done lets the current transaction finish, then parks in INIT
  assign done_state = init_done ? IDLE : INIT;

  req_edge_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot (
    .clk          (clk),
    .rst_n        (rst_n),
    .rreq         (cpu_rreq),
    .wreq         (cpu_wreq),
    .addr         (cpu_address),
    .wdata        (cpu_write_data),
    .take         (take),
    .cmd_valid    (sl_valid),
    .cmd_kind     (sl_kind),
    .cmd_addr     (sl_addr),
    .cmd_data     (sl_data),
    .pend_valid   (pend_valid),
    .err_overflow (err_overflow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= INIT;
      cmd_addr        <= '0;
      cmd_data        <= '0;
      cnt             <= '0;
      cpu_read_data   <= '0;
      cpu_rdata_valid <= 1'b0;
      err_timeout     <= 1'b0;
    end else begin
      cpu_rdata_valid <= 1'b0;
      case (state)
        INIT: if (init_done) state <= IDLE;
        IDLE: begin
          if (!init_done) begin
            state <= INIT;
          end else if (sl_valid) begin
            cmd_addr <= sl_addr;
            cmd_data <= sl_data;
            state    <= (sl_kind == CMD_WR) ? WR : RD_CMD;
          end
        end
        WR: if (!avm_waitrequest) state <= done_state;
        RD_CMD: begin
          if (!avm_waitrequest) begin
            state <= RD_WAIT;
            cnt   <= '0;
          end
        end
        RD_WAIT: begin
          if (avm_readdatavalid) begin
            cpu_read_data   <= avm_readdata;
            cpu_rdata_valid <= 1'b1;
            state           <= done_state;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            err_timeout <= 1'b1;
            state       <= done_state;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  assign avm_address    = cmd_addr;
  assign avm_writedata  = cmd_data;
  assign avm_write      = (state == WR);
  assign avm_read       = (state == RD_CMD);
  assign avm_byteenable = '1;
  assign cpu_busy       = (state != IDLE) | pend_valid;
endmodule
